id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Decode-to-execute pipeline register of the RV32 core, sitting directly upstream of the ALU. It captures a decoded instruction's operands and ALU operation, and applies operand forwarding from the MEM and WB stages, including refresh while stalled. It then presents registered `A`/`B`/`prog` values to the ALU under a valid/ready handshake with stall and flush support.

## Interface
- `ALU_ADD`, 3'b000, prog code for add (shared defines header)
- `ALU_OR`, 3'b001, prog code for or
- `ALU_SRL`, 3'b010, prog code for logical shift right
- `ALU_SLTU`, 3'b011, prog code for set-less-than-unsigned
- `ALU_SUB`, 3'b100, prog code for subtract
- `clk` in 1: single clock, rising edge
- `rst` in 1: reset, asynchronous, active-high
- `in_valid` in 1: decode presents an instruction
- `in_ready` out 1: stage can accept this cycle
- `in_rs1_addr`, `in_rs2_addr`, `in_rd_addr` in 5: register indices
- `in_rs1_data`, `in_rs2_data` in 32: register-file read data
- `in_imm` in 32: sign-extended immediate
- `in_use_imm` in 1: B operand is immediate, not rs2
- `in_alu_op` in 3: ALU prog code
- `in_reg_write` in 1: instruction writes rd
- `flush` in 1: kill held and incoming instruction
- `mem_reg_write`, `mem_rd_addr`, `mem_result` in 1/5/32: MEM-stage forward source
- `wb_reg_write`, `wb_rd_addr`, `wb_result` in 1/5/32: WB-stage forward source
- `out_valid` out 1: held entry valid
- `out_ready` in 1: ALU/MEM side accepts this cycle
- `alu_a`, `alu_b` out 32: registered operands to ALU `A`/`B`
- `alu_prog` out 3: registered op to ALU `prog`
- `out_rd_addr` out 5, `out_reg_write` out 1: carried to downstream stages

## Operation
- Single entry. `in_ready = !out_valid || out_ready` (combinational; independent of `in_valid`).
- Accept when `in_valid && in_ready && !flush`. Next cycle: `out_valid=1`, all fields loaded.
- Pop when `out_valid && out_ready`. Pop and accept in the same cycle: new entry replaces old, `out_valid` stays 1.
- Pop without accept: `out_valid` goes to 0. Fields hold their last values (don't-care).
- `flush`: `out_valid` goes to 0 next cycle. Flush overrides accept.
- Forward match for source s (rs1, or rs2 when `!in_use_imm`): `X_reg_write && X_rd_addr==s_addr && s_addr!=0`.
- Capture priority: MEM match, then WB match, then register-file data.
- Source address 0 always yields operand 0, whatever the register-file data.
- `alu_b` takes `in_imm` when `in_use_imm`; no forwarding on the immediate.
- Stalled refresh: while `out_valid && !out_ready`, a WB match on the held rs1/rs2 address (held addr≠0; rs2 only if held `use_imm`=0) overwrites the held operand.
  - Only WB refreshes; MEM is ignored while stalled. The producer reaches WB before the consumer leaves.
  - The held stage therefore also stores rs1/rs2 addresses and `use_imm`.
- `out_reg_write` with `out_rd_addr==0` passes through unchanged; suppression happens downstream.
- Invalid `in_alu_op` codes (101–111) are passed unchanged; the ALU treats them as add.

## Timing
- Reset (async, immediate): `out_valid=0`, `alu_a=0`, `alu_b=0`, `alu_prog=ALU_ADD`, `out_rd_addr=0`, `out_reg_write=0`, internal addr/`use_imm` = 0. `in_ready=1` while reset is deasserted.
- Latency: 1 cycle from accept edge to outputs valid. Throughput: 1 instruction/cycle when `out_ready=1`.
- Forward sources are sampled at the accepting edge; the refresh is applied at the stalled edge.
- Reset mid-stall drops the entry; no pop is signalled.
- All outputs are registered except `in_ready`.

## Test plan
- Reset asserted mid-stream with `out_valid=1` → all outputs zero in the same cycle, `in_ready=1` after release.
- Accept ADD, rs1=5 data 10, rs2=6 data 20, `out_ready=1` → next cycle `out_valid=1`, `alu_a=10`, `alu_b=20`, `alu_prog=000`. Back-to-back: 4 consecutive instructions give 4 consecutive valid cycles.
- Forwarding at capture:
  - rs1=7; MEM writes x7=0xAAAA and WB writes x7=0xBBBB in the same cycle → `alu_a=0xAAAA`.
  - rs2=0; WB writes x0=5, register-file data 9 → `alu_b=0`.
- Stall with `out_ready=0` for 3 cycles; WB writes held rs2 addr with 0x1234 in cycle 2 → `alu_b=0x1234` from cycle 3, still valid. `in_ready=0` throughout the stall.
- `use_imm=1`, imm=0xFFFFFFFC, WB matching rs2 addr → `alu_b=0xFFFFFFFC`, no override.
- `flush` together with `in_valid`: `in_ready=1` → `out_valid=0` next cycle. Flush while stalled → entry dropped, `in_ready=1` next cycle.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: decode-side, forwarding and ALU-side signals of the ID/EX register
interface id_ex_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1_addr;
    logic [4:0]  in_rs2_addr;
    logic [4:0]  in_rd_addr;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic [31:0] in_imm;
    logic        in_use_imm;
    logic [2:0]  in_alu_op;
    logic        in_reg_write;
    logic        flush;
    logic        mem_reg_write;
    logic [4:0]  mem_rd_addr;
    logic [31:0] mem_result;
    logic        wb_reg_write;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_prog;
    logic [4:0]  out_rd_addr;
    logic        out_reg_write;
    modport master (
        output in_valid, in_rs1_addr, in_rs2_addr, in_rd_addr, in_rs1_data, in_rs2_data,
               in_imm, in_use_imm, in_alu_op, in_reg_write, flush,
               mem_reg_write, mem_rd_addr, mem_result, wb_reg_write, wb_rd_addr, wb_result,
               out_ready,
        input  in_ready, out_valid, alu_a, alu_b, alu_prog, out_rd_addr, out_reg_write
    );
    modport slave (
        input  in_valid, in_rs1_addr, in_rs2_addr, in_rd_addr, in_rs1_data, in_rs2_data,
               in_imm, in_use_imm, in_alu_op, in_reg_write, flush,
               mem_reg_write, mem_rd_addr, mem_result, wb_reg_write, wb_rd_addr, wb_result,
               out_ready,
        output in_ready, out_valid, alu_a, alu_b, alu_prog, out_rd_addr, out_reg_write
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: single-entry decode-to-execute register with MEM/WB operand forwarding
module id_ex_stage (
    input logic          clk,
    input logic          rst,
    id_ex_stage_if.slave bus
);
    localparam logic [2:0] ALU_ADD = 3'b000;
    logic        valid_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [2:0]  prog_q;
    logic [4:0]  rd_q;
    logic        rw_q;
    logic [4:0]  rs1_q;
    logic [4:0]  rs2_q;
    logic        use_imm_q;
    logic        in_ready;
    logic        accept;
    logic        pop;
    logic        stall;
    logic        mem_m1;
    logic        mem_m2;
    logic        wb_m1;
    logic        wb_m2;
    logic        ref_a;
    logic        ref_b;
    logic [31:0] fwd_a;
    logic [31:0] fwd_b;
    always_comb begin
        in_ready = !valid_q || bus.out_ready;
        accept   = bus.in_valid && in_ready && !bus.flush;
        pop      = valid_q && bus.out_ready;
        stall    = valid_q && !bus.out_ready;
        mem_m1   = bus.mem_reg_write && bus.mem_rd_addr == bus.in_rs1_addr;
        mem_m2   = bus.mem_reg_write && bus.mem_rd_addr == bus.in_rs2_addr;
        wb_m1    = bus.wb_reg_write && bus.wb_rd_addr == bus.in_rs1_addr;
        wb_m2    = bus.wb_reg_write && bus.wb_rd_addr == bus.in_rs2_addr;
        fwd_a    = bus.in_rs1_addr == 5'd0 ? 32'd0 :
                   mem_m1 ? bus.mem_result :
                   wb_m1  ? bus.wb_result  : bus.in_rs1_data;
        fwd_b    = bus.in_use_imm ? bus.in_imm :
                   bus.in_rs2_addr == 5'd0 ? 32'd0 :
                   mem_m2 ? bus.mem_result :
                   wb_m2  ? bus.wb_result  : bus.in_rs2_data;
        // MEM is ignored while stalled: its producer reaches WB before this entry leaves
        ref_a    = stall && bus.wb_reg_write && rs1_q != 5'd0 && bus.wb_rd_addr == rs1_q;
        ref_b    = stall && !use_imm_q && bus.wb_reg_write && rs2_q != 5'd0 &&
                   bus.wb_rd_addr == rs2_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            prog_q    <= ALU_ADD;
            rd_q      <= 5'd0;
            rw_q      <= 1'b0;
            rs1_q     <= 5'd0;
            rs2_q     <= 5'd0;
            use_imm_q <= 1'b0;
        end else begin
            valid_q <= bus.flush ? 1'b0 : accept ? 1'b1 : pop ? 1'b0 : valid_q;
            if (accept) begin
                a_q       <= fwd_a;
                b_q       <= fwd_b;
                prog_q    <= bus.in_alu_op;
                rd_q      <= bus.in_rd_addr;
                rw_q      <= bus.in_reg_write;
                rs1_q     <= bus.in_rs1_addr;
                rs2_q     <= bus.in_rs2_addr;
                use_imm_q <= bus.in_use_imm;
            end else begin
                if (ref_a) a_q <= bus.wb_result;
                if (ref_b) b_q <= bus.wb_result;
            end
        end
    end
    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = valid_q;
    assign bus.alu_a         = a_q;
    assign bus.alu_b         = b_q;
    assign bus.alu_prog      = prog_q;
    assign bus.out_rd_addr   = rd_q;
    assign bus.out_reg_write = rw_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vector table plus hand-written stall, flush and reset sequences
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    id_ex_stage_if bus();
    id_ex_stage dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    typedef struct {
        logic vld; logic [4:0] rs1; logic [4:0] rs2; logic [4:0] rd;
        logic [31:0] d1; logic [31:0] d2; logic [31:0] imm; logic use_imm;
        logic [2:0] op; logic rw; logic fl;
        logic mw; logic [4:0] mrd; logic [31:0] mres;
        logic ww; logic [4:0] wrd; logic [31:0] wres;
        logic ev; logic [31:0] ea; logic [31:0] eb; logic [2:0] ep; logic [4:0] erd; logic erw;
    } vec_t;
    vec_t v [10];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask
    task automatic drive(input vec_t x);
        bus.in_valid = x.vld; bus.in_rs1_addr = x.rs1; bus.in_rs2_addr = x.rs2;
        bus.in_rd_addr = x.rd; bus.in_rs1_data = x.d1; bus.in_rs2_data = x.d2;
        bus.in_imm = x.imm; bus.in_use_imm = x.use_imm; bus.in_alu_op = x.op;
        bus.in_reg_write = x.rw; bus.flush = x.fl;
        bus.mem_reg_write = x.mw; bus.mem_rd_addr = x.mrd; bus.mem_result = x.mres;
        bus.wb_reg_write = x.ww; bus.wb_rd_addr = x.wrd; bus.wb_result = x.wres;
    endtask
    task automatic idle();
        vec_t z;
        z = '{0,0,0,0,0,0,0,0,3'd0,0,0, 0,0,0, 0,0,0, 0,0,0,3'd0,0,0};
        drive(z);
    endtask
    task automatic simple(input logic [4:0] rs1, input logic [31:0] d1,
                          input logic [4:0] rs2, input logic [31:0] d2);
        vec_t z;
        z = '{1,rs1,rs2,5'd1,d1,d2,0,0,3'd0,1,0, 0,0,0, 0,0,0, 0,0,0,3'd0,0,0};
        drive(z);
    endtask
    initial begin
        v[0] = '{1,5,6,3,10,20,0,0,3'd0,1,0, 0,0,0, 0,0,0, 1,10,20,3'd0,3,1};
        v[1] = '{1,7,8,4,1,'h55,0,0,3'd1,1,0, 1,7,'hAAAA, 1,7,'hBBBB, 1,'hAAAA,'h55,3'd1,4,1};
        v[2] = '{1,0,0,5,7,9,0,0,3'd2,0,0, 1,0,6, 1,0,5, 1,0,0,3'd2,5,0};
        v[3] = '{1,9,4,6,3,'h11,0,0,3'd4,1,0, 1,4,'h22, 1,9,'h77, 1,'h77,'h22,3'd4,6,1};
        v[4] = '{1,10,4,7,5,'h11,'hFFFFFFFC,1,3'd3,1,0, 0,0,0, 1,4,'h1111, 1,5,'hFFFFFFFC,3'd3,7,1};
        v[5] = '{1,1,1,0,'h42,'h43,0,0,3'd6,1,0, 0,1,'h99, 1,2,'h98, 1,'h42,'h43,3'd6,0,1};
        v[6] = '{0,1,2,3,4,5,0,0,3'd1,1,0, 0,0,0, 0,0,0, 0,0,0,3'd0,0,0};
        v[7] = '{1,1,2,3,4,5,0,0,3'd1,1,1, 0,0,0, 0,0,0, 0,0,0,3'd0,0,0};
        v[8] = '{1,12,12,31,1,2,0,0,3'd4,1,0, 1,12,'hDEAD, 1,12,'hBEEF, 1,'hDEAD,'hDEAD,3'd4,31,1};
        v[9] = '{1,31,30,2,1,7,0,0,3'd0,0,0, 1,30,'h8, 1,31,'hCAFE, 1,'hCAFE,'h8,3'd0,2,0};
        idle();
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, bus.out_valid}, 0);
        chk("rst_a", bus.alu_a, 0);
        chk("rst_b", bus.alu_b, 0);
        chk("rst_prog", {29'd0, bus.alu_prog}, 0);
        chk("rst_rd", {27'd0, bus.out_rd_addr}, 0);
        chk("rst_rw", {31'd0, bus.out_reg_write}, 0);
        @(negedge clk) rst = 1'b0;
        #1 chk("rst_rel_in_ready", {31'd0, bus.in_ready}, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk) drive(v[i]);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", i), {31'd0, bus.out_valid}, {31'd0, v[i].ev});
            if (v[i].ev) begin
                chk($sformatf("v%0d_a", i), bus.alu_a, v[i].ea);
                chk($sformatf("v%0d_b", i), bus.alu_b, v[i].eb);
                chk($sformatf("v%0d_prog", i), {29'd0, bus.alu_prog}, {29'd0, v[i].ep});
                chk($sformatf("v%0d_rd", i), {27'd0, bus.out_rd_addr}, {27'd0, v[i].erd});
                chk($sformatf("v%0d_rw", i), {31'd0, bus.out_reg_write}, {31'd0, v[i].erw});
            end
        end
        // back-to-back: four accepts give four valid cycles with matching operands
        for (int i = 0; i < 4; i++) begin
            @(negedge clk) simple(5'd3, 32'h100 + i, 5'd4, 32'h200 + i);
            @(posedge clk);
            #1;
            chk($sformatf("b2b%0d_valid", i), {31'd0, bus.out_valid}, 1);
            chk($sformatf("b2b%0d_a", i), bus.alu_a, 32'h100 + i);
        end
        @(negedge clk) idle();
        @(posedge clk);
        #1 chk("b2b_drain", {31'd0, bus.out_valid}, 0);
        // stall three cycles, WB refreshes held rs2 in cycle 2, MEM ignored in cycle 1
        @(negedge clk) simple(5'd2, 32'h10, 5'd3, 32'h20);
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        simple(5'd3, 32'h55, 5'd3, 32'h66);
        bus.mem_reg_write = 1'b1; bus.mem_rd_addr = 5'd3; bus.mem_result = 32'h9999;
        #1 chk("stall1_in_ready", {31'd0, bus.in_ready}, 0);
        @(posedge clk);
        #1 chk("stall1_b", bus.alu_b, 32'h20);
        @(negedge clk);
        bus.mem_reg_write = 1'b0;
        bus.wb_reg_write = 1'b1; bus.wb_rd_addr = 5'd3; bus.wb_result = 32'h1234;
        #1 chk("stall2_in_ready", {31'd0, bus.in_ready}, 0);
        @(posedge clk);
        #1 chk("stall2_b", bus.alu_b, 32'h1234);
        @(negedge clk) bus.wb_reg_write = 1'b0;
        #1 chk("stall3_in_ready", {31'd0, bus.in_ready}, 0);
        @(posedge clk);
        #1;
        chk("stall3_valid", {31'd0, bus.out_valid}, 1);
        chk("stall3_a", bus.alu_a, 32'h10);
        chk("stall3_b", bus.alu_b, 32'h1234);
        @(negedge clk);
        idle();
        bus.out_ready = 1'b1;
        #1 chk("unstall_in_ready", {31'd0, bus.in_ready}, 1);
        @(posedge clk);
        #1 chk("unstall_pop", {31'd0, bus.out_valid}, 0);
        // stalled entry with immediate B: WB on rs2 must not touch B, but refreshes rs1
        @(negedge clk);
        simple(5'd6, 32'h1, 5'd6, 32'h2);
        bus.in_use_imm = 1'b1; bus.in_imm = 32'h7;
        @(posedge clk);
        @(negedge clk);
        idle();
        bus.out_ready = 1'b0;
        bus.wb_reg_write = 1'b1; bus.wb_rd_addr = 5'd6; bus.wb_result = 32'hABCD;
        @(posedge clk);
        #1;
        chk("imm_stall_b", bus.alu_b, 32'h7);
        chk("imm_stall_a", bus.alu_a, 32'hABCD);
        // flush while stalled drops the entry
        @(negedge clk);
        idle();
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        chk("flush_stall_valid", {31'd0, bus.out_valid}, 0);
        chk("flush_stall_in_ready", {31'd0, bus.in_ready}, 1);
        // async reset with a valid entry clears outputs without a clock edge
        @(negedge clk);
        bus.out_ready = 1'b1;
        simple(5'd5, 32'h33, 5'd6, 32'h44);
        bus.in_alu_op = 3'd4;
        @(posedge clk);
        #1 chk("pre_rst_valid", {31'd0, bus.out_valid}, 1);
        bus.out_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, bus.out_valid}, 0);
        chk("mid_rst_a", bus.alu_a, 0);
        chk("mid_rst_b", bus.alu_b, 0);
        chk("mid_rst_prog", {29'd0, bus.alu_prog}, 0);
        chk("mid_rst_rd", {27'd0, bus.out_rd_addr}, 0);
        chk("mid_rst_rw", {31'd0, bus.out_reg_write}, 0);
        @(negedge clk);
        idle();
        rst = 1'b0;
        #1 chk("post_rst_in_ready", {31'd0, bus.in_ready}, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
